// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions for the ID/EX stage.
// Contents:
//   OPC_*    major opcode values (instr[6:0])
//   ALUOP_*  ALUOp encodings produced by the main controller
//   PCREG_*  PC_Reg encodings (PC-relative writeback source)
//   ctrl_t   packed bundle of the 8 decode control fields carried into EX
//   gate_ctrl helper that forces a control bundle to a bubble
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_R      = 2'b10;
  localparam logic [1:0] ALUOP_I      = 2'b11;

  localparam logic [1:0] PCREG_NONE  = 2'b00;
  localparam logic [1:0] PCREG_AUIPC = 2'b01;
  localparam logic [1:0] PCREG_JAL   = 2'b10;
  localparam logic [1:0] PCREG_JALR  = 2'b11;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
    logic [1:0] pc_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // An invalid decode slot must never carry side-effecting control into EX.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    return valid ? c : CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// Combinational load-use hazard detection for the decode slot.
// Ports:
//   id_valid_i    decode slot holds a real instruction
//   id_opcode     decode instruction opcode
//   id_rs1/id_rs2 decode source register indices
//   ex_valid      EX slot valid
//   ex_memread    EX instruction is a load
//   ex_rd         EX destination register
//   uses_rs1/uses_rs2  decode instruction actually reads rs1/rs2
//   load_use      decode instruction needs the result of the load in EX
module id_hazard_detect
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  uses_rs1,
  output logic                  uses_rs2,
  output logic                  load_use
);

  // U-type and JAL have immediate bits where rs1 would sit; never a real read.
  assign uses_rs1 = !((id_opcode == OPC_LUI) || (id_opcode == OPC_AUIPC) ||
                      (id_opcode == OPC_JAL));
  assign uses_rs2 = (id_opcode == OPC_OP) || (id_opcode == OPC_STORE) ||
                    (id_opcode == OPC_BRANCH);

  // x0 is hardwired to zero, so a load targeting it never produces a dependency.
  assign load_use = ex_valid && ex_memread && (ex_rd != '0) && id_valid &&
                    ((uses_rs1 && (id_rs1 == ex_rd)) ||
                     (uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Registers decode-stage operands, instruction fields and control into EX with
// one cycle of latency, raises stall toward PC/IF-ID, and inserts bubbles on a
// load-use hazard or an EX redirect.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   id_*                       decode-stage instruction, operands and control
//   ex_hold                    freeze the ID/EX contents
//   ex_redirect                kill the decode slot (taken branch/jump in EX)
//   stall                      hold PC and IF/ID this cycle
//   ex_*                       registered EX-stage copies
// Optional feature macro ID_EX_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt
// saturating counters of load-use bubbles and redirect cycles.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int PERF_CNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [31:0]           id_instr,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic                  id_alusrc,
  input  logic                  id_memtoreg,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memwrite,
  input  logic                  id_branch,
  input  logic [1:0]            id_aluop,
  input  logic [1:0]            id_pc_reg,
  input  logic                  ex_hold,
  input  logic                  ex_redirect,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2:0]            ex_funct3,
  output logic [6:0]            ex_funct7,
  output logic                  ex_alusrc,
  output logic                  ex_memtoreg,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic                  ex_branch,
  output logic [1:0]            ex_aluop,
  output logic [1:0]            ex_pc_reg
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt
`endif
);

  // Decode field extraction
  logic [6:0]            id_opcode;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
  ctrl_t                 id_ctrl;

  assign id_opcode = id_instr[6:0];
  assign id_rd     = id_instr[7  +: REG_ADDR_W];
  assign id_rs1    = id_instr[15 +: REG_ADDR_W];
  assign id_rs2    = id_instr[20 +: REG_ADDR_W];
  assign id_ctrl   = '{alusrc:   id_alusrc,   memtoreg: id_memtoreg,
                       regwrite: id_regwrite, memread:  id_memread,
                       memwrite: id_memwrite, branch:   id_branch,
                       aluop:    id_aluop,    pc_reg:   id_pc_reg};

  // Pipeline state
  logic                  valid_q,    valid_d;
  logic [XLEN-1:0]       pc_q,       pc_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]       imm_q,      imm_d;
  logic [REG_ADDR_W-1:0] rs1_q,      rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q,      rs2_d;
  logic [REG_ADDR_W-1:0] rd_q,       rd_d;
  logic [2:0]            funct3_q,   funct3_d;
  logic [6:0]            funct7_q,   funct7_d;
  ctrl_t                 ctrl_q,     ctrl_d;

  logic uses_rs1, uses_rs2, load_use;

  id_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_valid   (valid_q),
    .ex_memread (ctrl_q.memread),
    .ex_rd      (rd_q),
    .uses_rs1   (uses_rs1),
    .uses_rs2   (uses_rs2),
    .load_use   (load_use)
  );

  // A redirect discards the decode slot, so there is nothing left to stall for.
  assign stall = (load_use || ex_hold) && !ex_redirect;

  // Priority: redirect (bubble) > hold (keep) > load-use (bubble) > load.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    funct7_d   = funct7_q;
    ctrl_d     = ctrl_q;
    if (ex_redirect || (!ex_hold && load_use)) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      funct3_d   = '0;
      funct7_d   = '0;
      ctrl_d     = CTRL_BUBBLE;
    end else if (!ex_hold) begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      funct3_d   = id_instr[14:12];
      funct7_d   = id_instr[31:25];
      ctrl_d     = gate_ctrl(id_ctrl, id_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      ctrl_q     <= CTRL_BUBBLE;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      funct7_q   <= funct7_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_funct3   = funct3_q;
  assign ex_funct7   = funct7_q;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_branch   = ctrl_q.branch;
  assign ex_aluop    = ctrl_q.aluop;
  assign ex_pc_reg   = ctrl_q.pc_reg;

`ifdef ID_EX_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // A load-use bubble is only actually inserted when neither redirect nor hold win.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_use && !ex_hold && !ex_redirect && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (ex_redirect && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, load-use stall, hazard-free
// cases, flush, hold, reset during a stall and (with ID_EX_PERF_CNT_EN) the
// saturating performance counters.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            id_valid = 1'b0;
  logic [XLEN-1:0] id_pc = '0;
  logic [31:0]     id_instr = '0;
  logic [XLEN-1:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic id_alusrc = 0, id_memtoreg = 0, id_regwrite = 0, id_memread = 0;
  logic id_memwrite = 0, id_branch = 0;
  logic [1:0] id_aluop = '0, id_pc_reg = '0;
  logic ex_hold = 1'b0, ex_redirect = 1'b0;

  logic            stall, ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [RW-1:0]   ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
  logic [1:0] ex_aluop, ex_pc_reg;
`ifdef ID_EX_PERF_CNT_EN
  logic [1:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_stage #(
    .XLEN(XLEN), .REG_ADDR_W(RW)
`ifdef ID_EX_PERF_CNT_EN
    , .PERF_CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_aluop(id_aluop), .id_pc_reg(id_pc_reg),
    .ex_hold(ex_hold), .ex_redirect(ex_redirect), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_aluop(ex_aluop), .ex_pc_reg(ex_pc_reg)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Absolute bound on run time in case anything stalls the sequence.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic alusrc, input logic memtoreg, input logic regwrite,
                          input logic memread, input logic memwrite, input logic [1:0] aluop);
    id_alusrc = alusrc; id_memtoreg = memtoreg; id_regwrite = regwrite;
    id_memread = memread; id_memwrite = memwrite; id_branch = 1'b0;
    id_aluop = aluop; id_pc_reg = 2'b00;
  endtask

  task automatic drive_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc);
    id_valid = 1'b1; id_pc = pc;
    id_instr = {12'h004, rs1, 3'b010, rd, 7'b0000011};
    id_rs1_data = pc ^ 32'hA5A5_0000; id_rs2_data = 32'h0; id_imm = 32'h4;
    set_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
  endtask

  task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] pc);
    id_valid = 1'b1; id_pc = pc;
    id_instr = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    id_rs1_data = pc ^ 32'h1234_0000; id_rs2_data = pc ^ 32'h5678_0000; id_imm = 32'h0;
    set_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
  endtask

  task automatic drive_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] pc);
    id_valid = 1'b1; id_pc = pc;
    id_instr = {7'b0000000, rs2, rs1, 3'b010, 5'b01000, 7'b0100011};
    id_rs1_data = 32'h0; id_rs2_data = pc ^ 32'h0BAD_0000; id_imm = 32'h8;
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
  endtask

  task automatic drive_lui(input logic [4:0] rd, input logic [19:0] imm20, input logic [31:0] pc);
    id_valid = 1'b1; id_pc = pc;
    id_instr = {imm20, rd, 7'b0110111};
    id_rs1_data = 32'h0; id_rs2_data = 32'h0; id_imm = {imm20, 12'h000};
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_lw(5'd5, 5'd1, 32'h40);
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ex_valid); end
    checks++; if (ex_regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b expected 0", ex_regwrite); end
    checks++; if (ex_memread !== 1'b0) begin errors++; $display("FAIL reset_memread: got %b expected 0", ex_memread); end
    checks++; if (ex_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", ex_pc); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    $display("reset: ex_valid=%b ex_regwrite=%b stall=%b", ex_valid, ex_regwrite, stall);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    drive_lw(5'd5, 5'd1, 32'h100);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL lw_valid: got %b expected 1", ex_valid); end
    checks++; if (ex_rd !== 5'd5) begin errors++; $display("FAIL lw_rd: got %0d expected 5", ex_rd); end
    checks++; if (ex_memread !== 1'b1) begin errors++; $display("FAIL lw_memread: got %b expected 1", ex_memread); end
    checks++; if (ex_funct3 !== 3'b010) begin errors++; $display("FAIL lw_funct3: got %b expected 010", ex_funct3); end
    checks++; if (ex_pc !== 32'h100) begin errors++; $display("FAIL lw_pc: got %h expected 100", ex_pc); end
    checks++; if (ex_imm !== 32'h4) begin errors++; $display("FAIL lw_imm: got %h expected 4", ex_imm); end
    drive_add(5'd6, 5'd5, 5'd7, 32'h104);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_rs1: got %b expected 1", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid: got %b expected 0", ex_valid); end
    checks++; if (ex_regwrite !== 1'b0) begin errors++; $display("FAIL lu_bubble_regwrite: got %b expected 0", ex_regwrite); end
    checks++; if (ex_pc !== 32'h0) begin errors++; $display("FAIL lu_bubble_pc: got %h expected 0", ex_pc); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_drop: got %b expected 0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", ex_valid); end
    checks++; if (ex_rs1 !== 5'd5) begin errors++; $display("FAIL add_rs1: got %0d expected 5", ex_rs1); end
    checks++; if (ex_rs2 !== 5'd7) begin errors++; $display("FAIL add_rs2: got %0d expected 7", ex_rs2); end
    checks++; if (ex_rd !== 5'd6) begin errors++; $display("FAIL add_rd: got %0d expected 6", ex_rd); end
    checks++; if (ex_aluop !== 2'b10) begin errors++; $display("FAIL add_aluop: got %b expected 10", ex_aluop); end
    checks++; if (ex_rs1_data !== 32'h1234_0104) begin errors++; $display("FAIL add_rs1_data: got %h expected 12340104", ex_rs1_data); end
    checks++; if (ex_rs2_data !== 32'h5678_0104) begin errors++; $display("FAIL add_rs2_data: got %h expected 56780104", ex_rs2_data); end
    $display("load_use rs1: add reached EX pc=%h rs1=%0d", ex_pc, ex_rs1);
    // Hazard through rs2 of a store.
    drive_lw(5'd8, 5'd2, 32'h108);
    tick();
    drive_sw(5'd8, 5'd2, 32'h10C);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_rs2: got %b expected 1", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu2_bubble_valid: got %b expected 0", ex_valid); end
    tick();
    checks++; if (ex_memwrite !== 1'b1) begin errors++; $display("FAIL sw_memwrite: got %b expected 1", ex_memwrite); end
    checks++; if (ex_rs2 !== 5'd8) begin errors++; $display("FAIL sw_rs2: got %0d expected 8", ex_rs2); end
    $display("load_use rs2: sw reached EX pc=%h", ex_pc);
  endtask

  task automatic test_no_hazard();
    drive_lw(5'd0, 5'd1, 32'h200);
    tick();
    drive_add(5'd6, 5'd0, 5'd7, 32'h204);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nh_x0_stall: got %b expected 0", stall); end
    tick();
    checks++; if (ex_rd !== 5'd6) begin errors++; $display("FAIL nh_x0_rd: got %0d expected 6", ex_rd); end
    drive_lw(5'd5, 5'd1, 32'h208);
    tick();
    // imm20 bits [7:3] land on instr[19:15] = 5, which must not count as rs1.
    drive_lui(5'd5, 20'h00028, 32'h20C);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nh_lui_stall: got %b expected 0", stall); end
    tick();
    checks++; if (ex_pc !== 32'h20C) begin errors++; $display("FAIL nh_lui_pc: got %h expected 20c", ex_pc); end
    drive_lw(5'd5, 5'd1, 32'h210);
    tick();
    drive_add(5'd6, 5'd5, 5'd7, 32'h214);
    id_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nh_invalid_stall: got %b expected 0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL inv_valid: got %b expected 0", ex_valid); end
    checks++; if (ex_regwrite !== 1'b0) begin errors++; $display("FAIL inv_regwrite: got %b expected 0", ex_regwrite); end
    $display("no_hazard: x0, lui and invalid slot produced no stall");
  endtask

  task automatic test_flush();
    drive_lw(5'd5, 5'd1, 32'h300);
    tick();
    drive_sw(5'd5, 5'd2, 32'h304);
    ex_redirect = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall_mask: got %b expected 0", stall); end
    tick();
    ex_redirect = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b expected 0", ex_valid); end
    checks++; if (ex_memwrite !== 1'b0) begin errors++; $display("FAIL fl_memwrite: got %b expected 0", ex_memwrite); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall_after: got %b expected 0", stall); end
    tick();
    checks++; if (ex_memwrite !== 1'b1) begin errors++; $display("FAIL fl_sw_loaded: got %b expected 1", ex_memwrite); end
    ex_hold = 1'b1;
    ex_redirect = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flh_stall: got %b expected 0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flh_valid: got %b expected 0", ex_valid); end
    checks++; if (ex_memwrite !== 1'b0) begin errors++; $display("FAIL flh_memwrite: got %b expected 0", ex_memwrite); end
    ex_hold = 1'b0;
    ex_redirect = 1'b0;
    $display("flush: redirect flushed EX with and without hold");
  endtask

  task automatic test_hold();
    drive_add(5'd6, 5'd1, 5'd2, 32'h400);
    tick();
    checks++; if (ex_pc !== 32'h400) begin errors++; $display("FAIL hold_pre_pc: got %h expected 400", ex_pc); end
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_add(5'd9, 5'd3, 5'd4, 32'h404 + 32'(4 * i));
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall_%0d: got %b expected 1", i, stall); end
      tick();
      checks++; if (ex_pc !== 32'h400) begin errors++; $display("FAIL hold_pc_%0d: got %h expected 400", i, ex_pc); end
      checks++; if (ex_rd !== 5'd6) begin errors++; $display("FAIL hold_rd_%0d: got %0d expected 6", i, ex_rd); end
    end
    ex_hold = 1'b0;
    tick();
    checks++; if (ex_pc !== 32'h40C) begin errors++; $display("FAIL hold_resume_pc: got %h expected 40c", ex_pc); end
    checks++; if (ex_rd !== 5'd9) begin errors++; $display("FAIL hold_resume_rd: got %0d expected 9", ex_rd); end
    $display("hold: EX frozen 3 cycles, resumed with pc=%h", ex_pc);
  endtask

  task automatic test_reset_mid_stall();
    drive_lw(5'd5, 5'd1, 32'h600);
    tick();
    drive_add(5'd6, 5'd5, 5'd7, 32'h604);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_stall_pre: got %b expected 1", stall); end
    rst_n = 1'b0;
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rms_valid: got %b expected 0", ex_valid); end
    checks++; if (ex_memread !== 1'b0) begin errors++; $display("FAIL rms_memread: got %b expected 0", ex_memread); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL rms_rd: got %0d expected 0", ex_rd); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_stall: got %b expected 0", stall); end
    rst_n = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
      errors++; $display("FAIL rms_resume: got valid=%b rd=%0d expected valid=1 rd=6", ex_valid, ex_rd);
    end
    $display("reset_mid_stall: state cleared, add loaded after reset");
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (perf_stall_cnt !== 2'd0 || perf_flush_cnt !== 2'd0) begin
      errors++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_stall_cnt, perf_flush_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      drive_lw(5'd5, 5'd1, 32'h700);
      tick();
      drive_add(5'd6, 5'd5, 5'd7, 32'h704);
      tick();
      if (i == 2) begin
        checks++; if (perf_stall_cnt !== 2'd3) begin errors++; $display("FAIL perf_stall_3: got %0d expected 3", perf_stall_cnt); end
      end
    end
    checks++; if (perf_stall_cnt !== 2'd3) begin errors++; $display("FAIL perf_stall_sat: got %0d expected 3", perf_stall_cnt); end
    ex_redirect = 1'b1;
    tick(); tick();
    checks++; if (perf_flush_cnt !== 2'd2) begin errors++; $display("FAIL perf_flush_2: got %0d expected 2", perf_flush_cnt); end
    tick(); tick();
    ex_redirect = 1'b0;
    checks++; if (perf_flush_cnt !== 2'd3) begin errors++; $display("FAIL perf_flush_sat: got %0d expected 3", perf_flush_cnt); end
    $display("perf: stall_cnt=%0d flush_cnt=%0d", perf_stall_cnt, perf_flush_cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_hold();
    test_reset_mid_stall();
`ifdef ID_EX_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
